// File: rtl/pivot_swap_if.sv
// pivot_swap_if: command/result handshake and matrix RAM port of pivot_swap.
//   slave  : pivot_swap side (takes command and read data, drives result and RAM)
//   master : controller/RAM side
//   start, mxsize, col         - command pulse with matrix order and pivot column
//   busy, done                 - operation in progress / one-cycle completion
//   swapped, singular          - sign-flip flag / zero pivot or bad command
//   pivot_row, pivot_value     - selected row and its raw IEEE-754 word
//   ram_addr, ram_wdata, ram_we, ram_rdata - single-port RAM, 1-cycle read latency
interface pivot_swap_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [5:0]        mxsize;
   logic [4:0]        col;
   logic              busy;
   logic              done;
   logic              swapped;
   logic              singular;
   logic [4:0]        pivot_row;
   logic [31:0]       pivot_value;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic              ram_we;
   logic [31:0]       ram_rdata;

   modport slave (
      input  start, mxsize, col, ram_rdata,
      output busy, done, swapped, singular, pivot_row, pivot_value,
             ram_addr, ram_wdata, ram_we
   );

   modport master (
      output start, mxsize, col, ram_rdata,
      input  busy, done, swapped, singular, pivot_row, pivot_value,
             ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/pivot_swap.sv
// pivot_swap: partial-pivoting stage. Scans column k, rows k..n-1, of the
// matrix RAM for the largest magnitude, then swaps row k with the pivot row
// across columns k..n-1 when they differ.
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low
//   bus   - pivot_swap_if.slave: command, result flags and RAM port
//
// state  | meaning
// IDLE   | waiting for start; done pulses here for one cycle after an op
// SCAN   | presenting (r,k) for r = k..n-1, comparing returned words
// SLAST  | last scan word returning
// DECIDE | singular / no-swap / swap decision
// RDA    | read (k,c)
// RDB    | read (p,c), capture A
// WRA    | write B to (k,c); B is the word returning this cycle
// WRB    | write A to (p,c); advance column or finish
// FIN    | single busy cycle for a rejected command
module pivot_swap #(
   parameter int ROW_STRIDE = 32,
   parameter int ADDR_W     = 10
) (
   input  logic        clk,
   input  logic        reset,
   pivot_swap_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_SCAN, S_SLAST, S_DECIDE, S_RDA, S_RDB, S_WRA, S_WRB, S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  n_q, n_d;
   logic [4:0]  k_q, k_d;
   logic [4:0]  row_q, row_d;
   logic [4:0]  data_row_q, data_row_d;
   logic        rd_vld_q, rd_vld_d;
   logic [30:0] max_mag_q, max_mag_d;
   logic [4:0]  max_row_q, max_row_d;
   logic [31:0] max_word_q, max_word_d;
   logic [4:0]  col_q, col_d;
   logic [31:0] a_q, a_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        swapped_q, swapped_d;
   logic        singular_q, singular_d;
   logic [4:0]  pivot_row_q, pivot_row_d;
   logic [31:0] pivot_value_q, pivot_value_d;

   logic [4:0]  last_row;
   assign last_row = 5'(n_q - 6'd1);

   function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] row, input logic [4:0] c);
      logic [31:0] lin;
      lin = 32'(row) * 32'(ROW_STRIDE) + 32'(c);
      return lin[ADDR_W-1:0];
   endfunction

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      k_d           = k_q;
      row_d         = row_q;
      data_row_d    = data_row_q;
      rd_vld_d      = 1'b0;
      max_mag_d     = max_mag_q;
      max_row_d     = max_row_q;
      max_word_d    = max_word_q;
      col_d         = col_q;
      a_d           = a_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      swapped_d     = swapped_q;
      singular_d    = singular_q;
      pivot_row_d   = pivot_row_q;
      pivot_value_d = pivot_value_q;

      case (state_q)
         S_IDLE: begin
            // The done cycle is still IDLE; a start there is not taken.
            if (bus.start && !done_q) begin
               n_d           = bus.mxsize;
               k_d           = bus.col;
               row_d         = bus.col;
               max_mag_d     = '0;
               max_row_d     = bus.col;
               max_word_d    = '0;
               busy_d        = 1'b1;
               swapped_d     = 1'b0;
               singular_d    = 1'b0;
               pivot_row_d   = '0;
               pivot_value_d = '0;
               if ((bus.mxsize == 6'd0) || (bus.mxsize > 6'd32) ||
                   ({1'b0, bus.col} >= bus.mxsize)) begin
                  singular_d = 1'b1;
                  state_d    = S_FIN;
               end else begin
                  state_d = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            rd_vld_d   = 1'b1;
            data_row_d = row_q;
            if (row_q == last_row) state_d = S_SLAST;
            else                   row_d   = row_q + 5'd1;
         end
         S_SLAST: state_d = S_DECIDE;
         S_DECIDE: begin
            pivot_row_d   = max_row_q;
            pivot_value_d = max_word_q;
            if (max_mag_q == '0) begin
               singular_d = 1'b1;
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end else if (max_row_q == k_q) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               swapped_d = 1'b1;
               col_d     = k_q;
               state_d   = S_RDA;
            end
         end
         S_RDA: state_d = S_RDB;
         S_RDB: begin
            a_d     = bus.ram_rdata;
            state_d = S_WRA;
         end
         S_WRA: state_d = S_WRB;
         S_WRB: begin
            if (col_q == last_row) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               col_d   = col_q + 5'd1;
               state_d = S_RDA;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Row k's word always seeds the maximum; later rows need strictly
      // larger magnitude so ties stay on the lower row.
      if (rd_vld_q && ((data_row_q == k_q) || (bus.ram_rdata[30:0] > max_mag_q))) begin
         max_mag_d  = bus.ram_rdata[30:0];
         max_row_d  = data_row_q;
         max_word_d = bus.ram_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         n_q           <= '0;
         k_q           <= '0;
         row_q         <= '0;
         data_row_q    <= '0;
         rd_vld_q      <= 1'b0;
         max_mag_q     <= '0;
         max_row_q     <= '0;
         max_word_q    <= '0;
         col_q         <= '0;
         a_q           <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         swapped_q     <= 1'b0;
         singular_q    <= 1'b0;
         pivot_row_q   <= '0;
         pivot_value_q <= '0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         k_q           <= k_d;
         row_q         <= row_d;
         data_row_q    <= data_row_d;
         rd_vld_q      <= rd_vld_d;
         max_mag_q     <= max_mag_d;
         max_row_q     <= max_row_d;
         max_word_q    <= max_word_d;
         col_q         <= col_d;
         a_q           <= a_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         swapped_q     <= swapped_d;
         singular_q    <= singular_d;
         pivot_row_q   <= pivot_row_d;
         pivot_value_q <= pivot_value_d;
      end
   end

   // RAM port decoded straight from state so reset silences it immediately.
   // B is forwarded from the read port in WRA since it only arrives that cycle.
   always_comb begin
      bus.ram_addr  = '0;
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      case (state_q)
         S_SCAN: bus.ram_addr = addr_of(row_q, k_q);
         S_RDA:  bus.ram_addr = addr_of(k_q, col_q);
         S_RDB:  bus.ram_addr = addr_of(max_row_q, col_q);
         S_WRA: begin
            bus.ram_addr  = addr_of(k_q, col_q);
            bus.ram_we    = 1'b1;
            bus.ram_wdata = bus.ram_rdata;
         end
         S_WRB: begin
            bus.ram_addr  = addr_of(max_row_q, col_q);
            bus.ram_we    = 1'b1;
            bus.ram_wdata = a_q;
         end
         default: ;
      endcase
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.swapped     = swapped_q;
   assign bus.singular    = singular_q;
   assign bus.pivot_row   = pivot_row_q;
   assign bus.pivot_value = pivot_value_q;

endmodule

// File: doc/pivot_swap.md
# pivot_swap

Partial-pivoting stage that runs directly downstream of the matrix DMA loader in the determinant accelerator. For elimination step `col` it scans column `col`, rows `col..mxsize-1`, of the on-chip matrix RAM (row-major, row stride 32, IEEE-754 single words) and picks the entry with the largest magnitude. If that row is not `col`, it swaps the two rows in place, columns `col..mxsize-1`. It reports the pivot row, the pivot value, a swap flag (the determinant sign flip) and a singular flag to the elimination controller.

## Interface
- `ROW_STRIDE`, default 32: words per RAM row; RAM address = row*ROW_STRIDE + col.
- `ADDR_W`, default 10: matrix RAM address width.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs immediately.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `mxsize` in 6: matrix order n; valid range 1..32; sampled with `start`.
- `col` in 5: pivot column k, which is also the target row; sampled with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the result is valid.
- `swapped` out 1: rows were exchanged; held until the next accepted `start`.
- `singular` out 1: maximum magnitude was zero, or the command was invalid; held until the next accepted `start`.
- `pivot_row` out 5: selected row; held until the next accepted `start`.
- `pivot_value` out 32: raw word of the selected entry, including sign; held until the next accepted `start`.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_rdata` in 32: RAM read data; valid exactly 1 cycle after `ram_addr` is presented with `ram_we`=0.

## Operation
- Reset values: all outputs are 0, including `ram_addr`, `ram_wdata` and `ram_we`; the state is IDLE.
- **IDLE.** On `start`, capture n and k, then:
  - If n=0, n>32 or k>=n: go to FIN with `singular`=1 and `swapped`=0. No RAM access occurs.
  - Otherwise go to SCAN.
- **SCAN.** Present addresses (r,k) for r = k..n-1, one per cycle.
  - Each returned word w is compared by magnitude w[30:0] as an unsigned value. This is valid for non-NaN floats, and ±0 both count as 0.
  - The first word establishes the running maximum.
  - A later word replaces the running maximum only if its magnitude is strictly greater, so ties keep the lower row.
  - After the last data word returns, go to DECIDE.
- **DECIDE.**
  - If the maximum magnitude is 0: set `singular`=1 and `swapped`=0, and go to FIN.
  - Else if p==k: set `swapped`=0 and go to FIN.
  - Else: set `swapped`=1 and go to SWAP with c=k.
- **SWAP.** Four sub-states per column c, for c = k..n-1:
  - RDA: address (k,c), read.
  - RDB: address (p,c), read; capture A.
  - WRA: capture B; address (k,c), data B, `ram_we`=1.
  - WRB: address (p,c), data A, `ram_we`=1.
  - After column n-1, go to FIN.
- **FIN.** Pulse `done`, drop `busy`, return to IDLE.
- Every accepted `start` clears `swapped`, `singular`, `pivot_row` and `pivot_value` to 0 until they are updated.
- `start` while busy is ignored, with no effect on the operation in progress.
- `ram_we` is high only in WRA/WRB cycles. Columns below k are never touched.
- Counters: the row counter is 5 bits and never wraps past n-1. The address is computed as row*ROW_STRIDE+col, truncated to ADDR_W.
- Reset mid-operation: `ram_we` drops immediately. A swap that is partly written is left partly swapped; the controller must reload the matrix.

## Timing
- Cycle 0: `start` is sampled. Let m = n-k.
- Cycle 1: `busy`=1 and the first SCAN address is presented.
- SCAN: addresses on cycles 1..m; last data returns on cycle m+1.
- DECIDE: cycle m+2.
- No swap: `done` is on cycle m+3.
- Swap: 4 cycles per column, for 4m cycles on cycles m+3..5m+2; `done` is on cycle 5m+3.
- Invalid command: `done` is on cycle 2, with `busy` high on cycle 1 only.
- Result outputs are stable in the `done` cycle and remain stable afterwards.
- `busy` falls in the same cycle `done` is high.
- A new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- **Swap, positive maximum.** n=3, k=0, column 0 = {1.0 (0x3F800000), 2.0 (0x40000000), 4.0 (0x40800000)}; start.
  - Expect `pivot_row`=2, `pivot_value`=0x40800000, `swapped`=1, `singular`=0.
  - Rows 0 and 2 are exchanged across columns 0..2; row 1 is unchanged.
  - `done` on cycle 18.
- **Negative maximum.** n=2, k=0, column 0 = {5.0 (0x40A00000), -10.0 (0xC1200000)}.
  - Expect `pivot_row`=1, `pivot_value`=0xC1200000, `swapped`=1.
  - `done` on cycle 13.
- **Tie.** n=3, k=1, rows 1 and 2 hold 0x40000000 and 0xC0000000.
  - Expect `pivot_row`=1, `swapped`=0, no `ram_we` ever, `done` on cycle 5.
- **Singular.** n=4, k=1, column 1 rows 1..3 = {0x00000000, 0x80000000, 0x00000000}.
  - Expect `singular`=1, `swapped`=0, no writes.
  - `done` on cycle 6.
- **Invalid command and ignored start.**
  - n=3, k=3: expect `done` on cycle 2 with `singular`=1 and no RAM activity.
  - Then a valid command with a second `start` pulsed mid-SCAN: the second `start` is ignored and the single `done` keeps the timing above.
- **Reset mid-swap.** Assert `reset` low during a WRA cycle.
  - Expect `ram_we`, `busy` and `done` to go to 0 with no clock edge.
  - After release the block is in IDLE and accepts a new `start`.
